// File: rtl/sfp_accum.sv
// sfp_accum: drains OFIFO partial-sum words, accumulates them per address across
// n_pass passes, and emits finished words on the last pass. ReLU via SFP_RELU_EN.
`timescale 1ns/1ps
module sfp_accum #(
    parameter int COL     = 8,
    parameter int PSUM_BW = 16,
    parameter int DEPTH   = 16,
    parameter int ADDR_BW = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic [3:0]               n_pass,
    input  logic [ADDR_BW:0]         n_addr,
    input  logic [COL*PSUM_BW-1:0]   in,
    input  logic                     in_valid,
    output logic                     ofifo_rd,
    output logic [COL*PSUM_BW-1:0]   out,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic                     busy,
    output logic                     done
);

    localparam int W = COL * PSUM_BW;

    typedef enum logic {IDLE, ACC} state_t;

    state_t           state_q, state_d;
    logic [3:0]       p_q, p_d;
    logic [3:0]       n_pass_q, n_pass_d;
    logic [ADDR_BW:0] n_addr_q, n_addr_d;
    logic [ADDR_BW-1:0] a_q, a_d;
    logic [W-1:0]     out_q, out_d;
    logic             out_valid_q, out_valid_d;
    logic             done_q, done_d;

    logic [W-1:0]     acc_mem [DEPTH];
    logic [W-1:0]     acc_rd;
    logic [W-1:0]     sum_w;
    logic [W-1:0]     relu_w;
    logic             last_pass;
    logic             last_addr;
    logic             rd;

    assign acc_rd    = acc_mem[a_q];
    assign last_pass = (p_q == n_pass_q - 4'd1);
    assign last_addr = ({1'b0, a_q} == n_addr_q - (ADDR_BW+1)'(1));

    // On the final pass a read must not overwrite a word the consumer has not taken.
    assign rd = (state_q == ACC) && in_valid && (!last_pass || !out_valid_q || out_ready);

    generate
        for (genvar gi = 0; gi < COL; gi++) begin : g_lane
            logic [PSUM_BW-1:0] acc_l;
            logic [PSUM_BW-1:0] in_l;
            logic [PSUM_BW:0]   ext_sum;
            logic [PSUM_BW-1:0] lane_sum;

            assign acc_l   = acc_rd[gi*PSUM_BW +: PSUM_BW];
            assign in_l    = in[gi*PSUM_BW +: PSUM_BW];
            assign ext_sum = {acc_l[PSUM_BW-1], acc_l} + {in_l[PSUM_BW-1], in_l};

            always_comb begin
                lane_sum = ext_sum[PSUM_BW-1:0];
                if (p_q == 4'd0) begin
                    lane_sum = in_l;
                end else if (ext_sum[PSUM_BW] != ext_sum[PSUM_BW-1]) begin
                    lane_sum = ext_sum[PSUM_BW] ? {1'b1, {(PSUM_BW-1){1'b0}}}
                                                : {1'b0, {(PSUM_BW-1){1'b1}}};
                end
            end

            assign sum_w[gi*PSUM_BW +: PSUM_BW] = lane_sum;
`ifdef SFP_RELU_EN
            assign relu_w[gi*PSUM_BW +: PSUM_BW] = lane_sum[PSUM_BW-1] ? '0 : lane_sum;
`else
            assign relu_w[gi*PSUM_BW +: PSUM_BW] = lane_sum;
`endif
        end
    endgenerate

    always_comb begin
        state_d     = state_q;
        p_d         = p_q;
        a_d         = a_q;
        n_pass_d    = n_pass_q;
        n_addr_d    = n_addr_q;
        out_d       = out_q;
        out_valid_d = out_valid_q;
        done_d      = 1'b0;

        if (out_ready) begin
            out_valid_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                if (start) begin
                    n_pass_d = n_pass;
                    n_addr_d = n_addr;
                    p_d      = 4'd0;
                    a_d      = '0;
                    if (n_pass != 4'd0 && n_addr != '0) begin
                        state_d = ACC;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            ACC: begin
                if (rd) begin
                    if (last_addr) begin
                        a_d = '0;
                        p_d = p_q + 4'd1;
                    end else begin
                        a_d = a_q + ADDR_BW'(1);
                    end
                    if (last_pass) begin
                        out_d       = relu_w;
                        out_valid_d = 1'b1;
                        if (last_addr) begin
                            state_d = IDLE;
                            done_d  = 1'b1;
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            p_q         <= 4'd0;
            a_q         <= '0;
            n_pass_q    <= 4'd0;
            n_addr_q    <= '0;
            out_q       <= '0;
            out_valid_q <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            p_q         <= p_d;
            a_q         <= a_d;
            n_pass_q    <= n_pass_d;
            n_addr_q    <= n_addr_d;
            out_q       <= out_d;
            out_valid_q <= out_valid_d;
            done_q      <= done_d;
        end
    end

    // Bank is never cleared; pass 0 overwrites, and the final pass goes straight to out.
    always_ff @(posedge clk) begin
        if (!reset && rd && !last_pass) begin
            acc_mem[a_q] <= sum_w;
        end
    end

    assign ofifo_rd  = rd;
    assign out       = out_q;
    assign out_valid = out_valid_q;
    assign busy      = (state_q == ACC);
    assign done      = done_q;

endmodule

// File: tb/tb_sfp_accum.sv
// Directed testbench for sfp_accum: FWFT source queue, output capture, and
// immediate-assertion checks against hand-derived expected words.
`timescale 1ns/1ps
module tb_sfp_accum;

    logic         clk;
    logic         reset;
    logic         start;
    logic [3:0]   n_pass;
    logic [4:0]   n_addr;
    logic [127:0] in_w;
    logic         in_valid;
    logic         ofifo_rd;
    logic [127:0] out_w;
    logic         out_valid;
    logic         out_ready;
    logic         busy;
    logic         done;

    sfp_accum dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .n_pass   (n_pass),
        .n_addr   (n_addr),
        .in       (in_w),
        .in_valid (in_valid),
        .ofifo_rd (ofifo_rd),
        .out      (out_w),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .busy     (busy),
        .done     (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [127:0] src_q[$];
    logic [127:0] cap_q[$];
    logic [127:0] exp_q[$];
    int  rd_count, done_count;
    bit  gap_en, bp_en, bp_armed, chk_bp, chk_done;
    int  gap_left, bp_left;
    logic         prev_ov, prev_or;
    logic [127:0] prev_o;

    task automatic check(string tag, logic [127:0] obs, logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [127:0] word_all(logic [15:0] v);
        logic [127:0] w;
        for (int j = 0; j < 8; j++) w[16*j +: 16] = v;
        return w;
    endfunction

    function automatic logic [127:0] word_pk(int p, int k);
        logic [127:0] w;
        for (int j = 0; j < 8; j++) w[16*j +: 16] = 16'(p + k + j);
        return w;
    endfunction

    // Sum over passes 0..np-1 of (p+k+j)
    function automatic logic [127:0] exp_pk(int np, int k);
        logic [127:0] w;
        for (int j = 0; j < 8; j++) w[16*j +: 16] = 16'(np * (k + j) + np * (np - 1) / 2);
        return w;
    endfunction

    task automatic drive_src();
        in_valid = (src_q.size() > 0) && (gap_left == 0);
        in_w     = (src_q.size() > 0) ? src_q[0] : '0;
    endtask

    task automatic tick();
        logic rd_s, ov_s, or_s, d_s, b_s, iv_s;
        logic [127:0] o_s;
        @(negedge clk);
        rd_s = ofifo_rd; ov_s = out_valid; or_s = out_ready;
        d_s = done; b_s = busy; iv_s = in_valid; o_s = out_w;
        if (!iv_s) check("no_rd_without_valid", rd_s, 1'b0);
        if (prev_ov && !prev_or) begin
            check("out_valid_held", ov_s, 1'b1);
            check("out_stable", o_s, prev_o);
        end
        if (chk_bp && ov_s && !or_s) check("bp_rd_blocked", rd_s, 1'b0);
        if (d_s) begin
            done_count++;
            if (chk_done) begin
                check("done_with_last_valid", ov_s, 1'b1);
                check("busy_low_at_done", b_s, 1'b0);
            end
        end
        if (rd_s) rd_count++;
        if (ov_s && or_s) cap_q.push_back(o_s);
        prev_ov = ov_s; prev_or = or_s; prev_o = o_s;
        @(posedge clk);
        #1;
        if (rd_s && src_q.size() > 0) void'(src_q.pop_front());
        if (bp_en && bp_armed && ov_s) begin
            bp_left  = 5;
            bp_armed = 1'b0;
        end
        if (bp_left > 0) begin
            out_ready = 1'b0;
            bp_left--;
        end else begin
            out_ready = 1'b1;
        end
        if (gap_left > 0) gap_left--;
        else if (gap_en && $urandom_range(0, 2) == 0) gap_left = $urandom_range(1, 4);
        drive_src();
    endtask

    task automatic new_job();
        rd_count = 0; done_count = 0;
        cap_q.delete(); exp_q.delete();
    endtask

    task automatic start_job(logic [3:0] np, logic [4:0] na);
        n_pass = np; n_addr = na; start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic finish_job(string tag, int exp_rd);
        int n = 0;
        while (!(done_count > 0 && cap_q.size() >= exp_q.size()) && n < 400) begin
            tick();
            n++;
        end
        check({tag, "_done_count"}, done_count, 1);
        check({tag, "_word_count"}, cap_q.size(), exp_q.size());
        check({tag, "_rd_count"}, rd_count, exp_rd);
        for (int i = 0; i < exp_q.size() && i < cap_q.size(); i++)
            check($sformatf("%s_word%0d", tag, i), cap_q[i], exp_q[i]);
    endtask

    task automatic load_pk(int np, int na);
        for (int p = 0; p < np; p++)
            for (int k = 0; k < na; k++) src_q.push_back(word_pk(p, k));
        for (int k = 0; k < na; k++) exp_q.push_back(exp_pk(np, k));
        drive_src();
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; n_pass = '0; n_addr = '0;
        in_w = '0; in_valid = 1'b0; out_ready = 1'b1;
        gap_en = 0; bp_en = 0; bp_armed = 0; chk_bp = 0; chk_done = 1;
        gap_left = 0; bp_left = 0; prev_ov = 0; prev_or = 1; prev_o = '0;
        rd_count = 0; done_count = 0;
        tick(); tick();
        reset = 1'b0;
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_out", out_w, 128'd0);
        check("rst_ofifo_rd", ofifo_rd, 1'b0);

        // Single pass, two words: 5 then -3
        new_job();
        src_q.push_back(word_all(16'd5));
        src_q.push_back(word_all(16'hFFFD));
        drive_src();
        exp_q.push_back(word_all(16'd5));
`ifdef SFP_RELU_EN
        exp_q.push_back(word_all(16'h0000));
`else
        exp_q.push_back(word_all(16'hFFFD));
`endif
        start_job(4'd1, 5'd2);
        finish_job("p1a2", 2);

        // Three passes of four words: out = 3+3k+3j
        new_job();
        load_pk(3, 4);
        start_job(4'd3, 5'd4);
        finish_job("p3a4", 12);

        // Saturation: even lanes +0x7000, odd lanes 0x9000, lane 7 small
        new_job();
        begin
            logic [127:0] w, e;
            for (int j = 0; j < 8; j++) begin
                if (j == 7) begin
                    w[16*j +: 16] = 16'h0001; e[16*j +: 16] = 16'h0003;
                end else if (j % 2 == 0) begin
                    w[16*j +: 16] = 16'h7000; e[16*j +: 16] = 16'h7FFF;
                end else begin
                    w[16*j +: 16] = 16'h9000;
`ifdef SFP_RELU_EN
                    e[16*j +: 16] = 16'h0000;
`else
                    e[16*j +: 16] = 16'h8000;
`endif
                end
            end
            for (int p = 0; p < 3; p++) src_q.push_back(w);
            exp_q.push_back(e);
            drive_src();
        end
        start_job(4'd3, 5'd1);
        finish_job("sat", 3);

        // Backpressure on the final pass
        new_job();
        bp_en = 1; bp_armed = 1; chk_bp = 1;
        load_pk(2, 4);
        start_job(4'd2, 5'd4);
        finish_job("bp", 8);
        bp_en = 0; chk_bp = 0;

        // Random in_valid gaps give the same result as the gap-free run
        new_job();
        gap_en = 1;
        load_pk(3, 4);
        start_job(4'd3, 5'd4);
        finish_job("gaps", 12);
        gap_en = 0; gap_left = 0;
        for (int i = 0; i < 6; i++) tick();

        // Reset mid pass 1, then rerun the same job cleanly
        new_job();
        load_pk(3, 4);
        start_job(4'd3, 5'd4);
        for (int i = 0; i < 50 && rd_count < 6; i++) tick();
        check("midrst_reached_pass1", rd_count, 6);
        src_q.delete();
        drive_src();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("midrst_busy", busy, 1'b0);
        check("midrst_out_valid", out_valid, 1'b0);
        check("midrst_out", out_w, 128'd0);
        check("midrst_done", done, 1'b0);
        new_job();
        load_pk(3, 4);
        start_job(4'd3, 5'd4);
        finish_job("rerun", 12);

        // start while busy is ignored
        new_job();
        start_job(4'd1, 5'd2);
        start_job(4'd2, 5'd3);
        src_q.push_back(word_all(16'd7));
        src_q.push_back(word_all(16'd9));
        drive_src();
        exp_q.push_back(word_all(16'd7));
        exp_q.push_back(word_all(16'd9));
        finish_job("busy_start", 2);
        for (int i = 0; i < 5; i++) tick();
        check("busy_start_idle", busy, 1'b0);
        check("busy_start_one_done", done_count, 1);

        // Zero-size jobs: done pulse, no reads
        chk_done = 0;
        new_job();
        src_q.push_back(word_all(16'd1));
        drive_src();
        start_job(4'd2, 5'd0);
        tick();
        check("naddr0_busy", busy, 1'b0);
        for (int i = 0; i < 4; i++) tick();
        check("naddr0_done_count", done_count, 1);
        check("naddr0_rd_count", rd_count, 0);
        check("naddr0_src_left", src_q.size(), 1);
        new_job();
        start_job(4'd0, 5'd3);
        for (int i = 0; i < 4; i++) tick();
        check("npass0_done_count", done_count, 1);
        check("npass0_rd_count", rd_count, 0);
        src_q.delete();
        drive_src();
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sfp_accum.md
# sfp_accum

Special-function stage directly downstream of the corelet OFIFO. It drains column partial-sum words from the OFIFO and accumulates them across `n_pass` kernel passes into an internal per-address accumulator bank. On the final pass it emits each finished output word, optionally ReLU-clipped, to the next consumer (psum memory / output SRAM writer).

## Interface
- `col`, 8: number of column lanes per word.
- `psum_bw`, 16: signed width of each lane.
- `depth`, 16: accumulator bank entries (output addresses per pass).
- `addr_bw`, 4: log2(`depth`).
- `clk`  input  1  clock; all logic on rising edge.
- `reset`  input  1  synchronous, active-high reset.
- `start`  input  1  one-cycle pulse; latches `n_pass`/`n_addr`, begins job; ignored while `busy`.
- `n_pass`  input  4  passes to accumulate (1..15).
- `n_addr`  input  `addr_bw`+1  words per pass (1..`depth`).
- `in`  input  `col*psum_bw`  OFIFO read data (first-word-fall-through); lane j = bits [psum_bw*j +: psum_bw].
- `in_valid`  input  1  OFIFO has a word (OFIFO `o_valid`).
- `ofifo_rd`  output  1  consume `in` this cycle.
- `out`  output  `col*psum_bw`  finished output word.
- `out_valid`  output  1  `out` holds a word.
- `out_ready`  input  1  downstream accepts `out` this cycle.
- `busy`  output  1  job in progress.
- `done`  output  1  one-cycle pulse at job completion.

## Operation
- States: IDLE, ACC. Reset -> IDLE; pass counter `p`=0, address counter `a`=0, `out_valid`=0, `done`=0, `busy`=0, `out`=0. Accumulator contents are not cleared (pass 0 overwrites).
- IDLE: `start` with `n_pass`≠0 and `n_addr`≠0 -> ACC, counters 0. `start` with either zero -> stay IDLE, `done` pulses next cycle, no reads.
- ACC: `ofifo_rd` = `in_valid` AND (`p` < `n_pass`-1 OR NOT `out_valid` OR `out_ready`). Combinational.
- On each read: lane-wise `acc[a]` = `in` if `p`==0, else sat(`acc[a]` + `in`). `a` increments; at `a`==`n_addr`-1, `a` wraps to 0 and `p` increments.
- Final pass (`p`==`n_pass`-1) reads also load `out` with the summed value (through ReLU if enabled) and set `out_valid`. Final pass does not need to write `acc`.
- Last read of last pass: -> IDLE, `done` pulses.
- Saturating add per lane: result clamps to +2^(psum_bw-1)-1 / -2^(psum_bw-1); lanes independent.
- `in_valid` low: no read, counters and state hold.
- `out_valid` clears when `out_ready` and no new final-pass read in the same cycle; a simultaneous accept plus new read keeps it high with new data.
- `reset` in any state aborts the job and returns to the reset values above on the next edge.

## Timing
- `ofifo_rd` same cycle as qualifying `in_valid`; data sampled on that edge.
- `out`/`out_valid` registered: valid one cycle after the final-pass read.
- `done` is registered and coincides with `out_valid` for the job's last word. `busy` falls in the same cycle.
- Throughput one word/cycle with `in_valid` and `out_ready` held high.
- `out` is stable while `out_valid`=1 and `out_ready`=0.

## Configuration
- `SFP_RELU_EN` defined: each output lane < 0 is forced to 0 before loading `out`. Accumulation itself stays signed and unclipped.
- Undefined: `out` carries the signed saturated sum unchanged.

## Test plan
- `n_pass`=1, `n_addr`=2, lanes 5 then -3 (all lanes) -> `out` 5, then 0 with `SFP_RELU_EN` or -3 (0xFFFD) without; `done` pulses with the second `out_valid`.
- `n_pass`=3, `n_addr`=4, word k of pass p has lane j = p+k+j -> addr k lane j out = 3+3k+3j; exactly 12 `ofifo_rd` pulses.
- Saturation: `n_pass`=3, `n_addr`=1, lane 0x7000 each pass -> 0x7FFF. Lane 0x9000 each pass -> 0x8000, or 0 with ReLU.
- Backpressure: `out_ready` low 5 cycles during the final pass -> `ofifo_rd` low after the first output, `out` stable, then resumes with no word lost or duplicated.
- `in_valid` gaps of random length mid-pass -> no reads and no counter movement during gaps; results equal the gap-free run.
- `reset` asserted mid-pass 1, then restart the same job -> identical outputs to a clean run. `start` while `busy` -> ignored; `n_addr`=0 -> `done` pulse, no reads.
